// File: rtl/reaction_timer.sv
// Reaction-time game core: random pre-GO delay, ms reaction counter,
// false-start detection. Outputs feed the display and LED stages.
module reaction_timer #(
    parameter int TICK_DIV     = 50000,
    parameter int MIN_DELAY_MS = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    output logic [13:0] value,
    output logic        led_go,
    output logic        foul,
    output logic        busy
);

    localparam int          PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [13:0] VMAX = 14'd9999;

    typedef enum logic [2:0] {IDLE, DELAY, TIMING, DONE, FOUL} state_t;

    state_t        state, state_n;
    logic          start_q, stop_q;
    logic          start_e, stop_e;
    logic [15:0]   lfsr;
    logic [PW-1:0] presc;
    logic          tick;
    logic          enter_cnt;
    logic [15:0]   delay_ms, delay_n;
    logic [13:0]   value_n;
    logic          led_go_n, foul_n, busy_n;

    assign start_e   = start & ~start_q;
    assign stop_e    = stop & ~stop_q;
    assign tick      = (presc == PW'(TICK_DIV - 1));
    // Entering a counting state restarts the ms prescaler so the first ms is full length.
    assign enter_cnt = (state_n != state) && (state_n == DELAY || state_n == TIMING);

    // One delay register per button gives a single-cycle event per press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            start_q <= start;
            stop_q  <= stop;
        end
    end

    // Free-running Fibonacci LFSR, taps 16,14,13,11; non-zero seed keeps it off all-zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr <= 16'hACE1;
        else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    // Millisecond prescaler: wraps at TICK_DIV-1, restarted on entry to DELAY/TIMING.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  presc <= '0;
        else if (enter_cnt || tick) presc <= '0;
        else                        presc <= presc + 1'b1;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state logic; stop wins in the active states, start wins in the rest states.
    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE, FOUL: if (start_e) state_n = DELAY;
            DELAY: begin
                if (stop_e)                           state_n = FOUL;
                else if (tick && delay_ms <= 16'd1)   state_n = TIMING;
            end
            TIMING: begin
                if (stop_e || (tick && value == VMAX - 14'd1)) state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Output/datapath next values; the indicator outputs are decoded from next state
    // so their registers change on the same edge as the state register.
    always_comb begin
        value_n = value;
        delay_n = delay_ms;
        case (state)
            IDLE, DONE, FOUL: begin
                if (start_e) begin
                    value_n = '0;
                    delay_n = 16'(MIN_DELAY_MS) + {6'd0, lfsr[9:0]};
                end
            end
            DELAY: begin
                if (!stop_e && tick && delay_ms != 16'd0) delay_n = delay_ms - 16'd1;
                value_n = '0;
            end
            TIMING: begin
                // A tick coincident with stop still counts.
                if (tick && value < VMAX) value_n = value + 14'd1;
            end
            default: value_n = '0;
        endcase
        led_go_n = (state_n == TIMING);
        busy_n   = (state_n == DELAY) || (state_n == TIMING);
        foul_n   = (state_n == FOUL);
    end

    // Registered outputs and delay counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value    <= '0;
            delay_ms <= '0;
            led_go   <= 1'b0;
            busy     <= 1'b0;
            foul     <= 1'b0;
        end else begin
            value    <= value_n;
            delay_ms <= delay_n;
            led_go   <= led_go_n;
            busy     <= busy_n;
            foul     <= foul_n;
        end
    end

endmodule
